// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle logic/arith/shift ops plus iterative shift-add MUL
// and restoring DIVU/REMU, with a valid/ready handshake on both sides.
module multicycle_alu #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNTW  = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       Control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             Illegal
);

    localparam int unsigned SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_MUL  = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_DIVU = 4'b0111;
    localparam logic [3:0] OP_SLTU = 4'b1000;
    localparam logic [3:0] OP_REMU = 4'b1001;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state, state_next;
    logic [CNTW-1:0]   cnt;
    logic [3:0]        op;
    logic [WIDTH-1:0]  acc;   // MUL: partial product, DIV: partial remainder
    logic [WIDTH-1:0]  x;     // MUL: shifted multiplicand, DIV: divisor
    logic [WIDTH-1:0]  y;     // MUL: remaining multiplier, DIV: dividend -> quotient

    logic              accept;
    logic              is_multi;
    logic [WIDTH-1:0]  single_res;
    logic              single_ill;

    logic [WIDTH:0]    div_shift;
    logic [WIDTH:0]    div_diff;
    logic              div_neg;
    logic [WIDTH-1:0]  step_acc;
    logic [WIDTH-1:0]  step_x;
    logic [WIDTH-1:0]  step_y;
    logic [WIDTH-1:0]  step_res;

    assign accept = in_valid & in_ready;

    // Decode of the operation presented at the input, used only on the accept edge
    always_comb begin
        is_multi   = (Control == OP_MUL) ||
                     (((Control == OP_DIVU) || (Control == OP_REMU)) && (B != '0));
        single_res = '0;
        single_ill = 1'b0;
        case (Control)
            OP_AND:  single_res = A & B;
            OP_OR:   single_res = A | B;
            OP_ADD:  single_res = A + B;
            OP_SUB:  single_res = A - B;
            OP_SLL:  single_res = A << B[SHW-1:0];
            OP_SRL:  single_res = A >> B[SHW-1:0];
            OP_SLTU: single_res = WIDTH'(A < B);
            OP_MUL:  single_res = '0;
            OP_DIVU: single_res = '1;
            OP_REMU: single_res = A;
            default: single_ill = 1'b1;
        endcase
    end

    // One iteration of shift-add multiply or restoring division
    always_comb begin
        div_shift = {acc, y[WIDTH-1]};
        div_diff  = div_shift - {1'b0, x};
        div_neg   = div_diff[WIDTH];
        if (op == OP_MUL) begin
            step_acc = acc + (y[0] ? x : '0);
            step_x   = x << 1;
            step_y   = y >> 1;
        end else begin
            step_acc = div_neg ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
            step_x   = x;
            step_y   = {y[WIDTH-2:0], ~div_neg};
        end
        step_res = (op == OP_DIVU) ? step_y : step_acc;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = is_multi ? BUSY : DONE;
            BUSY:    if (cnt == CNTW'(1)) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath and registered handshake outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            op        <= '0;
            acc       <= '0;
            x         <= '0;
            y         <= '0;
            Result    <= '0;
            Zero      <= 1'b1;
            Illegal   <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            in_ready  <= (state_next == IDLE);
            out_valid <= (state_next == DONE);
            case (state)
                IDLE: begin
                    if (accept) begin
                        op <= Control;
                        if (is_multi) begin
                            cnt <= CNTW'(WIDTH);
                            acc <= '0;
                            x   <= (Control == OP_MUL) ? A : B;
                            y   <= (Control == OP_MUL) ? B : A;
                        end else begin
                            Result  <= single_res;
                            Zero    <= (single_res == '0);
                            Illegal <= single_ill;
                        end
                    end
                end
                BUSY: begin
                    cnt <= cnt - CNTW'(1);
                    acc <= step_acc;
                    x   <= step_x;
                    y   <= step_y;
                    if (cnt == CNTW'(1)) begin
                        Result  <= step_res;
                        Zero    <= (step_res == '0);
                        Illegal <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed testbench for multicycle_alu (WIDTH=32): latency, results, flags,
// backpressure, reset abort and issue interval.
module tb_multicycle_alu;

    localparam int unsigned WIDTH = 32;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_MUL  = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_DIVU = 4'b0111;
    localparam logic [3:0] OP_SLTU = 4'b1000;
    localparam logic [3:0] OP_REMU = 4'b1001;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       Control;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Result;
    logic             Zero;
    logic             Illegal;

    int total = 0;
    int bad   = 0;

    multicycle_alu #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Control   (Control),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Result    (Result),
        .Zero      (Zero),
        .Illegal   (Illegal)
    );

    always #5 clk = ~clk;

    // Present one op for one edge, then scramble the inputs
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        Control  = op;
        A        = a;
        B        = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        A        = $urandom;
        B        = $urandom;
        Control  = 4'($urandom);
    endtask

    task automatic wait_out(output int lat);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic retire;
        out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        A = '0; B = '0; Control = '0;
        #2;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("FAIL reset_hs: got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
        total++;
        if (Result !== 32'h0 || Zero !== 1'b1 || Illegal !== 1'b0) begin
            bad++; $display("FAIL reset_out: got res=%h z=%b ill=%b want 0 1 0", Result, Zero, Illegal);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("FAIL post_reset: got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_logic_ops;
        logic [3:0]  op   [7];
        logic [31:0] a    [7];
        logic [31:0] b    [7];
        logic [31:0] exp  [7];
        int lat;
        op  = '{OP_ADD, OP_AND, OP_OR, OP_SUB, OP_SLTU, OP_SLTU, OP_SLTU};
        a   = '{32'hFFFFFFFF, 32'hF0F01234, 32'hF0000000, 32'h0, 32'd3, 32'd5, 32'hFFFFFFFF};
        b   = '{32'h1, 32'h0FF0FFFF, 32'h0000000F, 32'h1, 32'd5, 32'd3, 32'h1};
        exp = '{32'h0, 32'h00F01234, 32'hF000000F, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0};
        for (int i = 0; i < 7; i++) begin
            issue(op[i], a[i], b[i]);
            wait_out(lat);
            total++;
            if (lat != 1 || Result !== exp[i] || Zero !== (exp[i] == 32'h0) || Illegal !== 1'b0) begin
                bad++;
                $display("FAIL logic[%0d]: got res=%h z=%b ill=%b lat=%0d want res=%h z=%b ill=0 lat=1",
                         i, Result, Zero, Illegal, lat, exp[i], exp[i] == 32'h0);
            end
            retire();
        end
    endtask

    task automatic test_mul;
        logic [31:0] a   [3];
        logic [31:0] b   [3];
        logic [31:0] exp [3];
        int  lat;
        bit  ir_seen;
        a   = '{32'h00010003, 32'hFFFFFFFF, 32'h0};
        b   = '{32'h00020005, 32'hFFFFFFFF, 32'd5};
        exp = '{32'h000B000F, 32'h00000001, 32'h0};
        for (int i = 0; i < 3; i++) begin
            issue(OP_MUL, a[i], b[i]);
            lat = 1; ir_seen = 1'b0;
            while (out_valid !== 1'b1 && lat < 200) begin
                if (in_ready !== 1'b0) ir_seen = 1'b1;
                @(posedge clk); #1;
                lat++;
            end
            total++;
            if (lat != 33 || Result !== exp[i] || Zero !== (exp[i] == 32'h0) || Illegal !== 1'b0) begin
                bad++;
                $display("FAIL mul[%0d]: got res=%h z=%b ill=%b lat=%0d want res=%h z=%b ill=0 lat=33",
                         i, Result, Zero, Illegal, lat, exp[i], exp[i] == 32'h0);
            end
            total++;
            if (ir_seen !== 1'b0) begin
                bad++; $display("FAIL mul_busy_ready[%0d]: got in_ready=1 in busy want 0", i);
            end
            retire();
        end
    endtask

    task automatic test_div;
        logic [3:0]  op   [6];
        logic [31:0] a    [6];
        logic [31:0] b    [6];
        logic [31:0] exp  [6];
        int          elat [6];
        int lat;
        op   = '{OP_DIVU, OP_REMU, OP_DIVU, OP_REMU, OP_DIVU, OP_DIVU};
        a    = '{32'd100, 32'd100, 32'd5, 32'd5, 32'hFFFFFFFF, 32'd7};
        b    = '{32'd7, 32'd7, 32'd0, 32'd0, 32'd1, 32'd100};
        exp  = '{32'd14, 32'd2, 32'hFFFFFFFF, 32'd5, 32'hFFFFFFFF, 32'd0};
        elat = '{33, 33, 1, 1, 33, 33};
        for (int i = 0; i < 6; i++) begin
            issue(op[i], a[i], b[i]);
            wait_out(lat);
            total++;
            if (lat != elat[i] || Result !== exp[i] || Zero !== (exp[i] == 32'h0) || Illegal !== 1'b0) begin
                bad++;
                $display("FAIL div[%0d]: got res=%h z=%b ill=%b lat=%0d want res=%h z=%b ill=0 lat=%0d",
                         i, Result, Zero, Illegal, lat, exp[i], exp[i] == 32'h0, elat[i]);
            end
            retire();
        end
    endtask

    task automatic test_shift_illegal;
        logic [3:0]  op   [5];
        logic [31:0] a    [5];
        logic [31:0] b    [5];
        logic [31:0] exp  [5];
        logic        eill [5];
        int lat;
        op   = '{OP_SLL, OP_SRL, OP_SRL, 4'b1111, 4'b1011};
        a    = '{32'h1, 32'h80000000, 32'h80000000, 32'h12345678, 32'hFFFFFFFF};
        b    = '{32'h00000121, 32'd31, 32'h0000003F, 32'h1, 32'h1};
        exp  = '{32'h2, 32'h1, 32'h1, 32'h0, 32'h0};
        eill = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 5; i++) begin
            issue(op[i], a[i], b[i]);
            wait_out(lat);
            total++;
            if (lat != 1 || Result !== exp[i] || Zero !== (exp[i] == 32'h0) || Illegal !== eill[i]) begin
                bad++;
                $display("FAIL shift_ill[%0d]: got res=%h z=%b ill=%b lat=%0d want res=%h z=%b ill=%b lat=1",
                         i, Result, Zero, Illegal, lat, exp[i], exp[i] == 32'h0, eill[i]);
            end
            retire();
        end
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        issue(OP_SUB, 32'd9, 32'd4);
        for (int i = 0; i < 5; i++) begin
            total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || Result !== 32'd5 || Zero !== 1'b0) begin
                bad++;
                $display("FAIL hold[%0d]: got ov=%b ir=%b res=%h z=%b want 1 0 00000005 0",
                         i, out_valid, in_ready, Result, Zero);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("FAIL release: got ir=%b ov=%b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_reset_abort;
        bit seen;
        int lat;
        issue(OP_MUL, 32'd3, 32'd4);
        repeat (9) begin @(posedge clk); #1; end
        reset = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || Result !== 32'h0 || Zero !== 1'b1 || Illegal !== 1'b0) begin
            bad++;
            $display("FAIL abort_state: got ir=%b ov=%b res=%h z=%b ill=%b want 1 0 0 1 0",
                     in_ready, out_valid, Result, Zero, Illegal);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++; $display("FAIL abort_no_valid: got out_valid=1 after abort want 0");
        end
        issue(OP_ADD, 32'd2, 32'd3);
        wait_out(lat);
        total++;
        if (lat != 1 || Result !== 32'd5 || Zero !== 1'b0 || Illegal !== 1'b0) begin
            bad++;
            $display("FAIL after_abort_add: got res=%h z=%b ill=%b lat=%0d want 00000005 0 0 1",
                     Result, Zero, Illegal, lat);
        end
        retire();
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b1;
        Control = OP_ADD; A = 32'd1; B = 32'd1; in_valid = 1'b1;
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b1 || Result !== 32'd2) begin
            bad++; $display("FAIL b2b_first: got ov=%b res=%h want 1 00000002", out_valid, Result);
        end
        A = 32'd2; B = 32'd2;
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL b2b_gap: got ov=%b ir=%b want 0 1", out_valid, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || Result !== 32'd4) begin
            bad++; $display("FAIL b2b_second: got ov=%b res=%h want 1 00000004", out_valid, Result);
        end
        retire();
    endtask

    initial begin
        test_reset();
        test_logic_ops();
        test_mul();
        test_div();
        test_shift_illegal();
        test_backpressure();
        test_reset_abort();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits; SHALL be legal for any power of two 8..64.
REQ-002 Parameter CNTW, default $clog2(WIDTH)+1, width of the iteration counter.
REQ-003 Port clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port in_valid  input  1  operands and Control valid.
REQ-006 Port in_ready  output  1  block can accept an operation.
REQ-007 Port A  input  WIDTH  operand A.
REQ-008 Port B  input  WIDTH  operand B.
REQ-009 Port Control  input  4  operation code.
REQ-010 Port out_valid  output  1  Result, Zero and Illegal valid.
REQ-011 Port out_ready  input  1  consumer accepts the result.
REQ-012 Port Result  output  WIDTH  registered result.
REQ-013 Port Zero  output  1  1 when Result == 0.
REQ-014 Port Illegal  output  1  1 when Control was an undefined code.

Function
REQ-015 Opcodes: 0000 AND; 0001 OR; 0010 ADD; 0100 SUB; 0101 SLL; 0110 SRL; 1000 SLTU; 0011 MUL; 0111 DIVU; 1001 REMU.
REQ-016 ADD/SUB/MUL SHALL wrap modulo 2^WIDTH; no carry or overflow output.
REQ-017 SLL/SRL SHALL use B[$clog2(WIDTH)-1:0] as the shift amount and ignore the upper bits of B; SRL is logical.
REQ-018 SLTU SHALL give 1 if A < B unsigned, else 0, zero-extended to WIDTH.
REQ-019 MUL SHALL give the low WIDTH bits of A*B (unsigned), computed by iterative shift-add, one bit per cycle.
REQ-020 DIVU/REMU SHALL compute the unsigned quotient/remainder by restoring division, one bit per cycle.
REQ-021 Division by zero: DIVU SHALL give all ones and REMU SHALL give A; both complete as single-cycle ops.
REQ-022 Undefined Control: Result=0, Zero=1, Illegal=1; completes as a single-cycle op. Illegal=0 for every defined op.
REQ-023 FSM states: IDLE, BUSY, DONE.
REQ-024 in_ready SHALL be 1 only in IDLE; an operation is accepted when in_valid & in_ready are both 1 at a clock edge.
REQ-025 At accept, A, B and Control SHALL be captured; later input changes SHALL NOT affect the operation in flight.
REQ-026 Single-cycle ops (including REQ-021/022): IDLE->DONE on accept; out_valid=1 in the cycle after accept (latency 1).
REQ-027 MUL/DIVU/REMU (B!=0): IDLE->BUSY on accept; counter loads WIDTH and decrements each BUSY cycle; at counter==1, BUSY->DONE; out_valid rises WIDTH+1 cycles after accept.
REQ-028 DONE: out_valid=1; Result, Zero and Illegal SHALL hold stable until out_ready=1, then DONE->IDLE on that edge.
REQ-029 No back-to-back overlap: a new accept SHALL NOT happen in the same cycle as DONE->IDLE; the minimum issue interval is 2 cycles.
REQ-030 out_valid=0 in IDLE and BUSY; Result may change in BUSY but SHALL NOT be consumed.
REQ-031 Zero SHALL be computed from the final registered Result, not from intermediate BUSY values.

Reset
REQ-032 While reset=1: state=IDLE, counter=0, in_ready=1, out_valid=0, Result=0, Zero=1, Illegal=0.
REQ-033 Reset asserted in BUSY or DONE SHALL abort the operation immediately; no out_valid follows for the aborted op.
REQ-034 After reset deasserts, the first clock edge with in_valid=1 SHALL accept the operation.

Verification
REQ-035 WIDTH=32, ADD A=0xFFFFFFFF B=1, out_ready=1 -> out_valid 1 cycle after accept, Result=0, Zero=1, Illegal=0.
REQ-036 MUL A=0x00010003 B=0x00020005 -> out_valid exactly 33 cycles after accept, Result=0x000B000F; in_ready=0 throughout BUSY.
REQ-037 DIVU A=100 B=7 then REMU A=100 B=7 -> Result=14, then 2; DIVU A=5 B=0 -> 0xFFFFFFFF after 1 cycle; REMU A=5 B=0 -> 5.
REQ-038 SLL A=1 B=0x00000121 -> Result=0x00000002 (shift amount 1); Control=1111 -> Result=0, Zero=1, Illegal=1.
REQ-039 Backpressure: SUB A=9 B=4 with out_ready=0 for 5 cycles -> Result=5 held, out_valid=1, in_ready=0; after out_ready=1, in_ready=1 the next cycle.
REQ-040 Reset pulse during MUL cycle 10 -> outputs at reset values, no out_valid; a following ADD 2+3 -> Result=5.
